// File: rtl/id_decode_stage.sv
// -----------------------------------------------------------------------------
// id_decode_stage
//
// Instruction-decode stage of a small in-order pipeline. One instruction at a
// time is taken from fetch into a one-entry hold register. It is decoded and
// then issued:
//   - to the register file as an immediate write (LDI), or
//   - to the register file read port and to EXE (READ / ALU), or
//   - to nowhere (NOP).
// A two-bit scoreboard tracks ALU results not yet retired by WB. Any READ or
// ALU that reaches decode while a result is pending stalls until WB retires it.
//
// Ports
//   sysclk_i     : sole clock, all state on the rising edge
//   reset_i      : synchronous active-high reset
//   if_valid_i   : fetch offers if_inst_i
//   if_inst_i    : op[7:6] dst[5] rsel[4:3] imm[4:0]
//   if_ready_o   : stage accepts if_inst_i this cycle
//   rf_rw_o      : register-file control, 1 only for the one-cycle LDI write
//   rf_wsel_o    : register-file write select (0=A, 1=B)
//   rf_rsel_o    : register-file read-port select
//   rf_w_o       : register-file write data
//   ex_valid_o   : decoded op offered to EXE
//   ex_ready_i   : EXE accepts the offered op
//   ex_op_o      : decoded opcode to EXE
//   ex_dst_o     : destination register to EXE
//   wb_done_i    : WB retires an ALU result this cycle
//   wb_sel_i     : register retired by WB
//   stall_cnt_o  : saturating count of cycles spent in hazard stall
// -----------------------------------------------------------------------------
module id_decode_stage #(
   parameter int unsigned STALL_CNT_W = 8
) (
   input  logic                   sysclk_i,
   input  logic                   reset_i,
   input  logic                   if_valid_i,
   input  logic [7:0]             if_inst_i,
   output logic                   if_ready_o,
   output logic                   rf_rw_o,
   output logic                   rf_wsel_o,
   output logic [1:0]             rf_rsel_o,
   output logic [7:0]             rf_w_o,
   output logic                   ex_valid_o,
   input  logic                   ex_ready_i,
   output logic [1:0]             ex_op_o,
   output logic                   ex_dst_o,
   input  logic                   wb_done_i,
   input  logic                   wb_sel_i,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'b00,
      ST_HELD      = 2'b01,
      ST_STALL_HAZ = 2'b10,
      ST_STALL_EX  = 2'b11
   } state_e;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LDI  = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;
   localparam logic [1:0] OP_ALU  = 2'b11;

   localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   // State and hold register
   state_e                 state_q, state_d;
   logic [7:0]             inst_q, inst_d;
   logic [1:0]             pend_q, pend_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Registered outputs
   logic                   rf_rw_q, rf_rw_d;
   logic                   rf_wsel_q, rf_wsel_d;
   logic [1:0]             rf_rsel_q, rf_rsel_d;
   logic [7:0]             rf_w_q, rf_w_d;
   logic                   ex_valid_q, ex_valid_d;
   logic [1:0]             ex_op_q, ex_op_d;
   logic                   ex_dst_q, ex_dst_d;

   // Decode / handshake signals
   logic       held_s;
   logic [1:0] op_s;
   logic       dst_s;
   logic [1:0] rsel_s;
   logic [4:0] imm_s;
   logic       hazard_s;
   logic       needs_ex_s;
   logic       ex_free_s;
   logic       issue_s;
   logic       if_ready_s;
   logic       accept_s;
   logic [1:0] pend_set_s;
   logic [1:0] pend_clr_s;

   // Decode the held instruction, then evaluate hazard, issue and the fetch handshake
   always_comb begin
      held_s = (state_q != ST_EMPTY);
      op_s   = inst_q[7:6];
      dst_s  = inst_q[5];
      rsel_s = inst_q[4:3];
      imm_s  = inst_q[4:0];

      hazard_s   = 1'b0;
      needs_ex_s = 1'b0;
      case (op_s)
         OP_NOP: begin
            hazard_s   = 1'b0;
            needs_ex_s = 1'b0;
         end
         OP_LDI: begin
            // An immediate write only collides with a pending result for the same register
            hazard_s   = pend_q[dst_s];
            needs_ex_s = 1'b0;
         end
         OP_READ, OP_ALU: begin
            hazard_s   = (pend_q != 2'b00);
            needs_ex_s = 1'b1;
         end
         default: begin
            hazard_s   = 1'b0;
            needs_ex_s = 1'b0;
         end
      endcase

      ex_free_s = !ex_valid_q || ex_ready_i;
      issue_s   = held_s && !hazard_s && (ex_free_s || !needs_ex_s);

      // Accept when empty, or when the held instruction leaves this cycle (no bubble).
      // Nothing is accepted while reset is asserted.
      if (reset_i) begin
         if_ready_s = 1'b0;
      end else begin
         if_ready_s = !held_s || issue_s;
      end
      accept_s = if_valid_i && if_ready_s;
   end

   assign if_ready_o = if_ready_s;

   // Next-state logic for the hold FSM and the hold register
   always_comb begin
      state_d = state_q;
      if (accept_s) begin
         inst_d = if_inst_i;
      end else begin
         inst_d = inst_q;
      end

      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               state_d = ST_HELD;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_HELD, ST_STALL_HAZ, ST_STALL_EX: begin
            if (issue_s) begin
               if (accept_s) begin
                  state_d = ST_HELD;
               end else begin
                  state_d = ST_EMPTY;
               end
            end else if (hazard_s) begin
               // Hazard wins over a busy EXE when both block issue
               state_d = ST_STALL_HAZ;
            end else begin
               state_d = ST_STALL_EX;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Output next-state: register-file control, EXE offer, scoreboard, stall counter
   always_comb begin
      rf_rw_d   = 1'b0;
      rf_wsel_d = rf_wsel_q;
      rf_rsel_d = rf_rsel_q;
      rf_w_d    = rf_w_q;
      // The EXE offer is withdrawn once taken, unless replaced below
      ex_valid_d = ex_valid_q && !ex_ready_i;
      ex_op_d    = ex_op_q;
      ex_dst_d   = ex_dst_q;

      if (issue_s) begin
         case (op_s)
            OP_LDI: begin
               rf_rw_d   = 1'b1;
               rf_wsel_d = dst_s;
               rf_w_d    = {3'b000, imm_s};
            end
            OP_READ, OP_ALU: begin
               rf_rsel_d  = rsel_s;
               ex_valid_d = 1'b1;
               ex_op_d    = op_s;
               ex_dst_d   = dst_s;
            end
            OP_NOP: begin
               rf_rw_d = 1'b0;
            end
            default: begin
               rf_rw_d = 1'b0;
            end
         endcase
      end else begin
         rf_rw_d = 1'b0;
      end

      // Scoreboard: a new ALU result for a register outranks its retirement in the same cycle
      if (issue_s && (op_s == OP_ALU)) begin
         pend_set_s = dst_s ? 2'b10 : 2'b01;
      end else begin
         pend_set_s = 2'b00;
      end
      if (wb_done_i) begin
         pend_clr_s = wb_sel_i ? 2'b10 : 2'b01;
      end else begin
         pend_clr_s = 2'b00;
      end
      pend_d = (pend_q & ~pend_clr_s) | pend_set_s;

      if ((state_q == ST_STALL_HAZ) && (stall_cnt_q != STALL_MAX)) begin
         stall_cnt_d = stall_cnt_q + STALL_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State, hold register, scoreboard, counter and output registers
   always_ff @(posedge sysclk_i) begin
      if (reset_i) begin
         state_q     <= ST_EMPTY;
         inst_q      <= 8'h00;
         pend_q      <= 2'b00;
         stall_cnt_q <= {STALL_CNT_W{1'b0}};
         rf_rw_q     <= 1'b0;
         rf_wsel_q   <= 1'b0;
         rf_rsel_q   <= 2'b00;
         rf_w_q      <= 8'h00;
         ex_valid_q  <= 1'b0;
         ex_op_q     <= 2'b00;
         ex_dst_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
         rf_rw_q     <= rf_rw_d;
         rf_wsel_q   <= rf_wsel_d;
         rf_rsel_q   <= rf_rsel_d;
         rf_w_q      <= rf_w_d;
         ex_valid_q  <= ex_valid_d;
         ex_op_q     <= ex_op_d;
         ex_dst_q    <= ex_dst_d;
      end
   end

   assign rf_rw_o     = rf_rw_q;
   assign rf_wsel_o   = rf_wsel_q;
   assign rf_rsel_o   = rf_rsel_q;
   assign rf_w_o      = rf_w_q;
   assign ex_valid_o  = ex_valid_q;
   assign ex_op_o     = ex_op_q;
   assign ex_dst_o    = ex_dst_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
